uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 88 ++++++++
 tb/tb_uart_tx_feeder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a UART transmitter one strobed byte at a time.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   enable                permits launching new bytes to the transmitter
//   wr_en, wr_data        host push strobe and byte
//   full, empty, count    FIFO occupancy (count excludes the byte held in Tx_DATA)
//   overflow              sticky, push attempted while full
//   tx_timeout            sticky, Tx_BUSY failed to rise after a strobe
//   Tx_EN, Tx_WR, Tx_DATA transmitter enable, one-cycle write strobe, byte
//   Tx_BUSY               transmitter busy status
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_timeout,
    output logic                     Tx_EN,
    output logic                     Tx_WR,
    output logic [7:0]               Tx_DATA,
    input  logic                     Tx_BUSY
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [7:0]    tmr;
    logic          push, pop;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push  = wr_en & ~full;
    // empty comes from the registered count, so a byte pushed at this edge is never popped at it
    assign pop   = (state == IDLE) & enable & ~empty & ~Tx_BUSY;
    // a launched frame keeps the transmitter enabled until it completes
    assign Tx_EN = enable | (state != IDLE);

    always_ff @(posedge clk)
        if (push) mem[wptr] <= wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
            Tx_WR      <= 1'b0;
            Tx_DATA    <= 8'h00;
            tmr        <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (wr_en & full) overflow <= 1'b1;
            if (push & ~pop) count <= count + 1'b1;
            else if (pop & ~push) count <= count - 1'b1;
            case (state)
                IDLE: if (pop) begin
                    Tx_DATA <= mem[rptr];
                    rptr    <= rptr + 1'b1;
                    Tx_WR   <= 1'b1;
                    state   <= LOAD;
                end
                LOAD: begin
                    Tx_WR <= 1'b0;
                    tmr   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (Tx_BUSY) state <= WAIT_DONE;
                else if (tmr == 8'(BUSY_TIMEOUT - 1)) begin
                    tx_timeout <= 1'b1;
                    state      <= IDLE;
                end else tmr <= tmr + 1'b1;
                WAIT_DONE: if (!Tx_BUSY) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: queue-based reference model plus directed scenarios for uart_tx_feeder.
module tb_uart_tx_feeder;
    localparam int DEPTH = 8;
    localparam int T     = 6;

    logic       clk = 0, reset = 1, enable = 0, wr_en = 0, Tx_BUSY = 0;
    logic [7:0] wr_data = 0, Tx_DATA;
    logic       full, empty, overflow, tx_timeout, Tx_EN, Tx_WR;
    logic [3:0] count;

    uart_tx_feeder #(.DEPTH(DEPTH), .BUSY_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_timeout(tx_timeout), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
        .Tx_BUSY(Tx_BUSY)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0, cyc = 0, busy_len = 3, bcnt = 0;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;

    // transmitter stand-in: goes busy the edge after a strobe for busy_len cycles (0 = never)
    always @(posedge clk)
        if (reset) begin
            Tx_BUSY <= 0;
            bcnt = 0;
        end else if (Tx_WR && busy_len != 0) begin
            Tx_BUSY <= 1;
            bcnt = busy_len;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) Tx_BUSY <= 0;
        end

    // reference model: queue of bytes plus frame phase (0 idle, 1 strobe, 2 await busy, 3 await done)
    logic [7:0] q[$];
    int         ph = 0, tmr = 0, sz = 0;
    bit         pop, m_wr = 0, m_ovf = 0, m_to = 0, mvalid = 0;
    logic [7:0] m_data = 0;

    always @(posedge clk)
        if (reset) begin
            q.delete();
            ph = 0; tmr = 0; m_wr = 0; m_data = 0; m_ovf = 0; m_to = 0; mvalid = 1;
        end else begin
            sz   = q.size();
            pop  = ph == 0 && enable && sz > 0 && !Tx_BUSY;
            m_wr = pop;
            if (ph == 1) begin
                ph = 2; tmr = 0;
            end else if (ph == 2) begin
                if (Tx_BUSY) ph = 3;
                else begin
                    tmr++;
                    if (tmr == T) begin m_to = 1; ph = 0; end
                end
            end else if (ph == 3 && !Tx_BUSY) ph = 0;
            if (pop) begin m_data = q.pop_front(); ph = 1; end
            if (wr_en) begin
                if (sz < DEPTH) q.push_back(wr_data);
                else m_ovf = 1;
            end
        end

    logic [7:0] logq[$];
    int         logc[$];
    int         to_cyc = -1;

    always @(negedge clk)
        if (mvalid) begin
            chk("count", 32'(count), q.size());
            chk("full", full, q.size() == DEPTH);
            chk("empty", empty, q.size() == 0);
            chk("overflow", overflow, m_ovf);
            chk("tx_timeout", tx_timeout, m_to);
            chk("Tx_WR", Tx_WR, m_wr);
            chk("Tx_DATA", Tx_DATA, m_data);
            chk("Tx_EN", Tx_EN, enable || ph != 0);
            if (Tx_WR === 1'b1) begin logq.push_back(Tx_DATA); logc.push_back(cyc); end
            if (tx_timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
        end

    function automatic logic [7:0] lg(int i);
        return i < logq.size() ? logq[i] : 8'hxx;
    endfunction

    function automatic int lc(int i);
        return i < logc.size() ? logc[i] : -1000;
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(logic [7:0] d);
        wr_en = 1; wr_data = d; step(); wr_en = 0;
    endtask

    int n0, n1, pc;
    logic [7:0] e040 [9] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};

    initial begin
        step(2); reset = 0; step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", empty, 1);
        chk("rst_data", Tx_DATA, 8'h00);

        // single byte into an idle feeder
        enable = 1; busy_len = 3; n0 = logq.size();
        push(8'h94); pc = cyc; step(10);
        chk("t035_n", logq.size() - n0, 1);
        chk("t035_data", lg(n0), 8'h94);
        chk("t035_lat", lc(n0) - pc, 1);
        chk("t035_count", 32'(count), 0);

        // two bytes against a long busy transmitter
        busy_len = 1000; n0 = logq.size();
        push(8'h94); push(8'hA1); step(2100);
        chk("t036_n", logq.size() - n0, 2);
        chk("t036_b0", lg(n0), 8'h94);
        chk("t036_b1", lg(n0 + 1), 8'hA1);
        chk("t036_gap", (lc(n0 + 1) - lc(n0)) > 1000, 1);

        // overfill while disabled, then drain across pointer wrap
        busy_len = 2; enable = 0; n0 = logq.size();
        for (int i = 0; i < DEPTH + 1; i++) push(8'h10 + 8'(i));
        chk("t037_full", full, 1);
        chk("t037_count", 32'(count), DEPTH);
        chk("t037_ovf", overflow, 1);
        enable = 1; step(100);
        chk("t037_n", logq.size() - n0, DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("t037_order", lg(n0 + i), 8'h10 + 8'(i));
        chk("t037_count0", 32'(count), 0);

        // transmitter never goes busy
        busy_len = 0; n0 = logq.size();
        push(8'h55); push(8'h66);
        for (int i = 0; i < 40 && to_cyc < 0; i++) step();
        chk("t038_seen", to_cyc >= 0, 1);
        chk("t038_delay", to_cyc - lc(n0), T + 1);
        step(20);
        chk("t038_b0", lg(n0), 8'h55);
        chk("t038_b1", lg(n0 + 1), 8'h66);

        // simultaneous push and pop, at count 4 and at full
        reset = 1; step(); reset = 0;
        chk("t040_ovf0", overflow, 0);
        chk("t040_to0", tx_timeout, 0);
        busy_len = 2; enable = 0; n0 = logq.size();
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        enable = 1; wr_en = 1; wr_data = 8'hA4; step(); enable = 0; wr_en = 0;
        chk("t040_same", 32'(count), 4);
        for (int i = 5; i < 9; i++) push(8'hA0 + 8'(i));
        chk("t040_full", full, 1);
        step(10);
        enable = 1; wr_en = 1; wr_data = 8'hFF; step(); wr_en = 0;
        chk("t040_count7", 32'(count), 7);
        chk("t040_ovf", overflow, 1);
        step(80);
        chk("t040_n", logq.size() - n0, 9);
        for (int i = 0; i < 9; i++) chk("t040_order", lg(n0 + i), e040[i]);

        // reset during a frame with bytes queued
        reset = 1; step(); reset = 0;
        busy_len = 1000; enable = 1; n0 = logq.size();
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        step(5);
        chk("t039_pre", 32'(count), 3);
        reset = 1; step(); reset = 0;
        chk("t039_count", 32'(count), 0);
        chk("t039_empty", empty, 1);
        chk("t039_full", full, 0);
        chk("t039_wr", Tx_WR, 0);
        chk("t039_data", Tx_DATA, 8'h00);
        chk("t039_flags", {overflow, tx_timeout}, 0);
        n1 = logq.size(); step(20);
        chk("t039_nowr", logq.size(), n1);
        chk("t039_one", n1 - n0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
